// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out stream shifter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam bit MSB_FIRST = 1'b0;
    localparam bit LSB_FIRST = 1'b1;

    function automatic int cnt_w(input int data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// Single-entry holding register with full flag.
module piso_hold_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         full
);

    import piso_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_stream.sv
// Handshaked PISO shifter with one-word hold buffer for gapless frames.
module piso_stream #(
    parameter int DATA_W     = 16,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              shift_en,
    output logic              dout,
    output logic              dout_valid,
    output logic              sof,
    output logic              eof,
    output logic              busy
);

    import piso_pkg::*;

    localparam int CW = cnt_w(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam bit LSBF = (LSB_FIRST == piso_pkg::LSB_FIRST);

    state_t            state, state_nx;
    logic [DATA_W-1:0] shreg, shreg_nx, hold_q;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              hold_full, hold_ld, hold_ul;
    logic              accept, last;

    assign din_ready = rst_n & ~hold_full;
    assign accept    = din_valid & din_ready;
    assign last      = (state == SHIFT) && (cnt == LAST) && shift_en;

    piso_hold_buf #(.W(DATA_W)) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (hold_ld),
        .unload (hold_ul),
        .d      (din),
        .q      (hold_q),
        .full   (hold_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        hold_ld  = 1'b0;
        hold_ul  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SHIFT;
                    shreg_nx = din;
                    cnt_nx   = '0;
                end
            end
            SHIFT: begin
                if (last) begin
                    // next word follows the last bit without a gap
                    cnt_nx = '0;
                    if (hold_full) begin
                        shreg_nx = hold_q;
                        hold_ul  = 1'b1;
                    end else if (accept) begin
                        shreg_nx = din;
                    end else begin
                        state_nx = IDLE;
                        shreg_nx = '0;
                    end
                end else begin
                    if (shift_en) begin
                        shreg_nx = LSBF ? (shreg >> 1) : (shreg << 1);
                        cnt_nx   = cnt + 1'b1;
                    end
                    hold_ld = accept;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dout = IDLE_LEVEL;
        if (state == SHIFT) begin
            dout = LSBF ? shreg[0] : shreg[DATA_W-1];
        end
    end

    assign dout_valid = (state == SHIFT);
    assign sof        = (state == SHIFT) && (cnt == '0);
    assign eof        = (state == SHIFT) && (cnt == LAST);
    assign busy       = (state == SHIFT) | hold_full;

endmodule

// File: tb/tb_piso_stream.sv
// Scoreboard bench: MSB/LSB 16-bit instances and a rate-gated 8-bit one.
module tb_piso_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] a_din, b_din;
    logic [7:0]  c_din;
    logic a_dv, a_se, a_rdy, a_dout, a_dval, a_sof, a_eof, a_busy;
    logic b_dv, b_se, b_rdy, b_dout, b_dval, b_sof, b_eof, b_busy;
    logic c_dv, c_se, c_rdy, c_dout, c_dval, c_sof, c_eof, c_busy;

    int checks = 0;
    int fails = 0;
    logic [2:0] qa[$];
    logic [2:0] qb[$];
    logic [2:0] qc[$];

    piso_stream #(.DATA_W(16), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .din(a_din), .din_valid(a_dv),
        .din_ready(a_rdy), .shift_en(a_se), .dout(a_dout),
        .dout_valid(a_dval), .sof(a_sof), .eof(a_eof), .busy(a_busy)
    );

    piso_stream #(.DATA_W(16), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_dv),
        .din_ready(b_rdy), .shift_en(b_se), .dout(b_dout),
        .dout_valid(b_dval), .sof(b_sof), .eof(b_eof), .busy(b_busy)
    );

    piso_stream #(.DATA_W(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .din(c_din), .din_valid(c_dv),
        .din_ready(c_rdy), .shift_en(c_se), .dout(c_dout),
        .dout_valid(c_dval), .sof(c_sof), .eof(c_eof), .busy(c_busy)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // expected entry = {dout, sof, eof}
    task automatic push(input int which, input logic [15:0] w);
        int n;
        logic b;
        n = (which == 2) ? 8 : 16;
        for (int i = 0; i < n; i++) begin
            b = (which == 1) ? w[i] : w[n-1-i];
            case (which)
                0: qa.push_back({b, i == 0, i == n - 1});
                1: qb.push_back({b, i == 0, i == n - 1});
                default: qc.push_back({b, i == 0, i == n - 1});
            endcase
        end
    endtask

    task automatic mon(input int which, input logic [2:0] got);
        int sz;
        logic [2:0] e;
        sz = (which == 0) ? qa.size() :
             (which == 1) ? qb.size() : qc.size();
        checks++;
        if (sz == 0) begin
            fails++;
            $display("FAIL mon%0d_unexpected: got %b expected none",
                     which, got);
        end else begin
            case (which)
                0: e = qa.pop_front();
                1: e = qb.pop_front();
                default: e = qc.pop_front();
            endcase
            if (got !== e) begin
                fails++;
                $display("FAIL mon%0d_bit: got %b expected %b",
                         which, got, e);
            end
        end
    endtask

    always @(negedge clk)
        if (rst_n && a_se && a_dval) mon(0, {a_dout, a_sof, a_eof});
    always @(negedge clk)
        if (rst_n && b_se && b_dval) mon(1, {b_dout, b_sof, b_eof});
    always @(negedge clk)
        if (rst_n && c_se && c_dval) mon(2, {c_dout, c_sof, c_eof});

    int a_vcnt = 0;
    int a_falls = 0;
    logic a_prev = 1'b0;
    always @(negedge clk) begin
        a_prev <= a_dval;
        if (a_dval) a_vcnt <= a_vcnt + 1;
        if (a_prev && !a_dval) a_falls <= a_falls + 1;
    end

    function automatic logic rdy(input int which);
        return (which == 0) ? a_rdy : (which == 1) ? b_rdy : c_rdy;
    endfunction

    function automatic logic dval(input int which);
        return (which == 0) ? a_dval : (which == 1) ? b_dval : c_dval;
    endfunction

    // leaves din_valid high; caller drops it when no word follows
    task automatic send(input int which, input logic [15:0] w);
        int n;
        n = 0;
        case (which)
            0: begin a_din = w; a_dv = 1'b1; end
            1: begin b_din = w; b_dv = 1'b1; end
            default: begin c_din = w[7:0]; c_dv = 1'b1; end
        endcase
        while (!rdy(which) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_ready_timeout", 32'(n < 300), 1);
        @(posedge clk);
        push(which, w);
        #1;
    endtask

    task automatic wait_idle(input int which, output int n);
        n = 0;
        while (dval(which) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1);
    end

    initial begin
        int n, bv, bf, vc, bm;
        a_din = '0; a_dv = 0; a_se = 0;
        b_din = '0; b_dv = 0; b_se = 0;
        c_din = '0; c_dv = 0; c_se = 0;
        #12;
        chk("rst_dout", a_dout, 0);
        chk("rst_dval", a_dval, 0);
        chk("rst_sof_eof", {a_sof, a_eof}, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_rdy, 0);
        chk("rst_idle_level_c", c_dout, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", a_rdy, 1);

        // MSB-first single word
        a_se = 1'b1;
        send(0, 16'hA5C3);
        a_dv = 1'b0;
        chk("msb_latency", {a_dval, a_sof}, 2'b11);
        wait_idle(0, n);
        chk("msb_len", n, 16);
        chk("msb_idle_dout", a_dout, 0);
        chk("msb_idle_busy", a_busy, 0);

        // LSB-first single word
        b_se = 1'b1;
        send(1, 16'hA5C3);
        b_dv = 1'b0;
        wait_idle(1, n);
        chk("lsb_len", n, 16);

        // gapless back-to-back
        bv = a_vcnt;
        bf = a_falls;
        send(0, 16'hFFFF);
        send(0, 16'h0000);
        a_dv = 1'b0;
        chk("gap_ready_low", a_rdy, 0);
        n = 0;
        while (!a_rdy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("gap_ready_cycles", n, 15);
        wait_idle(0, n);
        @(negedge clk);
        #1;
        chk("gap_valid_cycles", a_vcnt - bv, 32);
        chk("gap_valid_falls", a_falls - bf, 1);

        // hold buffer filled early in a word
        send(0, 16'h1234);
        a_dv = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send(0, 16'h5678);
        a_dv = 1'b0;
        chk("hold_ready_low", a_rdy, 0);
        chk("hold_busy", a_busy, 1);
        n = 0;
        while (!a_rdy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold_ready_cycles", n, 12);
        chk("hold_next_sof", {a_dval, a_sof}, 2'b11);
        wait_idle(0, n);

        // irregular shift_en on MSB-first word
        send(0, 16'h3C5A);
        a_dv = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (!a_dval) break;
            a_se = (k % 4 != 1);
            @(posedge clk);
            #1;
        end
        chk("gated_done", a_dval, 0);
        a_se = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("idle_shift_en_ignored", a_dval, 0);

        // 8-bit word, strobe every third clock
        send(2, 16'h0096);
        c_dv = 1'b0;
        vc = 0;
        bm = 0;
        for (int k = 0; k < 30; k++) begin
            if (c_dval) vc++;
            if (c_busy !== c_dval) bm++;
            c_se = (k % 3 == 2);
            @(posedge clk);
            #1;
        end
        c_se = 1'b0;
        chk("rate_valid_cycles", vc, 24);
        chk("rate_busy_tracks", bm, 0);
        chk("rate_idle_level", c_dout, 1);
        chk("rate_idle_busy", c_busy, 0);

        // reset mid-word with a word also held
        send(0, 16'hA5C3);
        send(0, 16'h1111);
        a_dv = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_dout", a_dout, 0);
        chk("midrst_dval", a_dval, 0);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_ready", a_rdy, 0);
        qa.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_no_resume", {a_dval, a_busy}, 0);
        send(0, 16'h0001);
        a_dv = 1'b0;
        wait_idle(0, n);
        chk("post_rst_len", n, 16);

        repeat (2) @(posedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out shifter that replaces the fixed 16-bit load-pulse PISO.
- Takes words over a valid/ready handshake and serialises them MSB- or LSB-first.
- Bit advance is gated by an external bit-rate enable.
- A one-word holding buffer gives gapless back-to-back frames. Output carries bit-valid and start/end-of-frame markers for downstream framing or line logic.

Parameters:
- DATA_W, 16, word width in bits (>=2).
- LSB_FIRST, 0, 0 = MSB shifted out first, 1 = LSB first.
- IDLE_LEVEL, 0, value driven on dout when no word is being shifted.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- din  in  DATA_W  parallel word.
- din_valid  in  1  din holds a word to transfer.
- din_ready  out  1  block can accept a word this cycle.
- shift_en  in  1  bit-rate strobe; advances one bit per clk with shift_en=1.
- dout  out  1  serial data bit.
- dout_valid  out  1  dout carries a frame bit.
- sof  out  1  dout is the first bit of a word.
- eof  out  1  dout is the last bit of a word.
- busy  out  1  shifter or holding buffer occupied.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - shifter empty, hold empty, bit counter 0, state IDLE.
  - dout=IDLE_LEVEL; dout_valid=sof=eof=busy=0; din_ready=0 while rst_n=0.
- Storage elements:
  - shreg[DATA_W-1:0].
  - bit counter cnt, width $clog2(DATA_W).
  - hold register plus hold_full flag.
- din_ready = rst_n & ~hold_full (combinational). Accept = din_valid & din_ready at a rising edge.
- States:
  - IDLE: shifter empty.
  - SHIFT: shifter holds a word.
- Load rules, evaluated per edge:
  - IDLE and accept: din loads directly into shreg, cnt=0, go SHIFT. First bit appears on dout the cycle after the accept edge (latency 1 clk).
  - SHIFT, last-bit edge (cnt==DATA_W-1 and shift_en), hold_full: hold loads into shreg, hold_full clears, cnt=0, stay SHIFT. Gapless.
  - SHIFT, last-bit edge, hold empty, accept same edge: din loads directly into shreg. Gapless.
  - SHIFT, last-bit edge, hold empty, no accept: go IDLE.
  - SHIFT, any other edge with accept: din goes to hold, hold_full set.
  - Accept while hold_full is impossible because din_ready=0.
- Shifting:
  - On shift_en in SHIFT, not last bit: cnt+1.
  - MSB-first: shreg shifts left, zero fill.
  - LSB-first: shreg shifts right, zero fill.
  - shift_en=0: all outputs hold.
- Outputs (combinational from registers):
  - dout = shreg[DATA_W-1] (MSB-first) or shreg[0] (LSB-first) in SHIFT; IDLE_LEVEL in IDLE.
  - dout_valid = (state==SHIFT).
  - sof = SHIFT & cnt==0.
  - eof = SHIFT & cnt==DATA_W-1.
  - busy = SHIFT | hold_full.
- Word duration: exactly DATA_W shift_en strobes. Each bit stays on dout until the next shift_en edge. shift_en tied high gives 1 bit/clk.
- shift_en asserted in IDLE: ignored.
- din is sampled only on the accept edge; changes while not accepted are ignored.
- Reset mid-word: the word and the held word are discarded immediately; no partial frame resumes after release.

Decomposition:
- Package piso_pkg:
  - state enum {IDLE, SHIFT}.
  - function cnt_w(DATA_W) = $clog2(DATA_W).
  - bit-order constants MSB_FIRST=0, LSB_FIRST=1.
- One sub-module, piso_hold_buf: single-entry register with full flag, load/unload ports and async active-low reset. Top-level piso_stream holds the FSM, shifter and counter.

Test Plan:
- Reset mid-word, shift_en=1: load 16'hA5C3, pull rst_n low at bit 5 -> dout=IDLE_LEVEL, dout_valid=0, busy=0 immediately. After release, first accept of 16'h0001 -> 15 zeros then 1, sof/eof correct.
- MSB-first, shift_en=1: accept 16'hA5C3 -> from next cycle dout = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. sof on bit0 only, eof on bit15 only, then dout_valid=0 and dout=0.
- LSB_FIRST=1, same word -> dout = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
- Gapless back-to-back: din_valid held high with 16'hFFFF then 16'h0000, shift_en=1 -> 32 consecutive dout_valid cycles (16 ones, 16 zeros), eof/sof adjacent. din_ready=0 from the cycle after the second accept until the third word's slot frees.
- Rate gating with DATA_W=8 and shift_en every 3rd clk: accept 8'h96 -> each bit held 3 clk, total 24 clk of dout_valid, busy drops with dout_valid.
- Hold buffer full: accept 16'h1234 then 16'h5678 early in the first word -> din_ready=0 until bit15 of 16'h1234 shifts, then 16'h5678 starts the next cycle with sof=1.
